// File: rtl/ay_ts_seq.sv
// rtl/ay_ts_seq.sv - TurboSound dual-AY bus sequencer with timed bdir/bc1 strobes
module ay_ts_seq #(
  parameter int SETUP_LEN = 1,
  parameter int PULSE_LEN = 6,
  parameter int HOLD_LEN  = 2
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       en,
  input  logic       ts_en,
  input  logic       a15,
  input  logic       a14,
  input  logic       a1,
  input  logic       iorq,
  input  logic       m1,
  input  logic       wr,
  input  logic [7:0] d,
  input  logic       ck35,
  output logic       ay_clk,
  output logic       ay0_bdir,
  output logic       ay0_bc1,
  output logic       ay1_bdir,
  output logic       ay1_bc1,
  output logic       d_out_active,
  output logic       cpuwait,
  output logic       sel
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [3:0] SETUP_INIT = 4'(SETUP_LEN - 1);
  localparam logic [3:0] PULSE_INIT = 4'(PULSE_LEN - 1);
  localparam logic [3:0] HOLD_INIT  = 4'(HOLD_LEN - 1);

  logic [2:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       op_bdir, op_bc1, tgt;
  logic       op_bdir_nxt, op_bc1_nxt, tgt_nxt;
  logic       op_read, op_read_nxt;
  logic       is_fffd, is_bffd, request, req_chipsel, req_ignored, req_accept;
  logic       drive_bdir, drive_bc1;

  // Port decode; BFFD reads are dropped, FE/FF address writes with TurboSound on select a chip
  assign is_fffd     = a15 & a14 & ~a1;
  assign is_bffd     = a15 & ~a14 & ~a1;
  assign request     = en & iorq & ~m1 & (is_fffd | is_bffd);
  assign req_chipsel = request & ts_en & is_fffd & wr & ((d == 8'hFF) || (d == 8'hFE));
  assign req_ignored = is_bffd & ~wr;
  assign req_accept  = request & ~req_ignored & ~req_chipsel;

  assign op_read     = ~op_bdir & op_bc1;
  assign op_read_nxt = ~op_bdir_nxt & op_bc1_nxt;

  // Next-state, counter and latched-operation logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    op_bdir_nxt = op_bdir;
    op_bc1_nxt  = op_bc1;
    tgt_nxt     = tgt;
    case (state)
      ST_IDLE: begin
        if (req_accept || req_chipsel) begin
          // bdir follows write, bc1 marks the FFFD port (ADDR or READ)
          op_bdir_nxt = wr;
          op_bc1_nxt  = is_fffd;
          tgt_nxt     = sel;
        end
        if (req_accept) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = SETUP_INIT;
        end else if (req_chipsel) begin
          state_nxt = ST_DONE;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_ACTIVE;
          cnt_nxt   = PULSE_INIT;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_ACTIVE: begin
        if (cnt == 4'd0) begin
          state_nxt = op_read ? ST_DONE : ST_HOLD;
          cnt_nxt   = op_read ? 4'd0 : HOLD_INIT;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (!iorq) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Strobe levels for the coming state, so the registered pins line up with the FSM
  always_comb begin
    drive_bdir = (state_nxt == ST_ACTIVE) & op_bdir_nxt;
    drive_bc1  = ((state_nxt == ST_ACTIVE) & op_bc1_nxt) |
                 ((state_nxt == ST_DONE) & op_read_nxt);
  end

  // FSM state, counter and latched operation/target
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      op_bdir <= 1'b0;
      op_bc1  <= 1'b0;
      tgt     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_bdir <= op_bdir_nxt;
      op_bc1  <= op_bc1_nxt;
      tgt     <= tgt_nxt;
    end
  end

  // Registered per-chip bus controls; only the latched target chip is ever strobed
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ay0_bdir <= 1'b0;
      ay0_bc1  <= 1'b0;
      ay1_bdir <= 1'b0;
      ay1_bc1  <= 1'b0;
    end else begin
      ay0_bdir <= drive_bdir & ~tgt_nxt;
      ay0_bc1  <= drive_bc1 & ~tgt_nxt;
      ay1_bdir <= drive_bdir & tgt_nxt;
      ay1_bc1  <= drive_bc1 & tgt_nxt;
    end
  end

  // Chip select: cleared whenever TurboSound is off, otherwise set by FE/FF address writes
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 1'b0;
    end else if (!ts_en) begin
      sel <= 1'b0;
    end else if ((state == ST_IDLE) && req_chipsel) begin
      sel <= (d == 8'hFE);
    end
  end

  // PSG clock divides the 3.5 MHz tick by two
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      ay_clk <= 1'b0;
    end else if (ck35) begin
      ay_clk <= ~ay_clk;
    end
  end

  // Wait and data-drive indications derived from state and registered strobes
  always_comb begin
    cpuwait = rst_n & (((state == ST_IDLE) & req_accept) |
                       (state == ST_SETUP) | (state == ST_ACTIVE) | (state == ST_HOLD));
    d_out_active = tgt ? (ay1_bc1 & ~ay1_bdir) : (ay0_bc1 & ~ay0_bdir);
  end

endmodule

// File: doc/ay_ts_seq.md
AY_TS_SEQ -- requirements
Module: ay_ts_seq

Interface
REQ-001 SETUP_LEN, 1, clk28 cycles strobes stay low after request accept, before strobe assertion; legal 1..15.
REQ-002 PULSE_LEN, 6, clk28 cycles bdir/bc1 asserted; legal 1..15.
REQ-003 HOLD_LEN, 2, clk28 cycles strobes low after pulse, before cpuwait release; legal 1..15.
REQ-004 clk28  in  1  system clock, 28 MHz.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  PSG port decode enable.
REQ-007 ts_en  in  1  TurboSound (dual-chip) enable.
REQ-008 a15, a14, a1  in  1 each  CPU address bits.
REQ-009 iorq, m1, wr  in  1 each  CPU strobes, active-high.
REQ-010 d  in  8  CPU data bus, valid during write cycles.
REQ-011 ck35  in  1  3.5 MHz tick, one clk28 cycle wide.
REQ-012 ay_clk  out  1  PSG clock, shared by both chips.
REQ-013 ay0_bdir, ay0_bc1, ay1_bdir, ay1_bc1  out  1 each  per-chip PSG bus controls.
REQ-014 d_out_active  out  1  selected PSG drives CPU data bus.
REQ-015 cpuwait  out  1  CPU wait request.
REQ-016 sel  out  1  currently selected chip (0/1).

Function
REQ-017 Decode: FFFD = a15&a14&!a1; BFFD = a15&!a14&!a1; request = en & iorq & !m1 & (FFFD|BFFD).
REQ-018 Op from request: FFFD&wr -> ADDR (bdir=1,bc1=1); BFFD&wr -> WRITE (bdir=1,bc1=0); FFFD&!wr -> READ (bdir=0,bc1=1); BFFD&!wr -> ignored, state unchanged, cpuwait low.
REQ-019 FSM states: IDLE, SETUP, ACTIVE, HOLD, DONE; 4-bit down-counter times SETUP/ACTIVE/HOLD.
REQ-020 IDLE: on posedge with non-ignored request, latch op and target chip (=sel), go SETUP with counter=SETUP_LEN-1.
REQ-021 SETUP: all strobes low; at counter 0 go ACTIVE with counter=PULSE_LEN-1.
REQ-022 ACTIVE: latched op's bdir/bc1 driven only on the latched chip's pins, other chip's pins low; at counter 0 go HOLD (ADDR/WRITE) or DONE (READ).
REQ-023 HOLD: strobes low; at counter 0 go DONE.
REQ-024 DONE: strobes low except READ keeps target bc1 high; leave to IDLE on first posedge with iorq=0.
REQ-025 All bdir/bc1 outputs registered; exactly SETUP_LEN cycles low then PULSE_LEN cycles high for ADDR/WRITE.
REQ-026 cpuwait combinational: high when request (non-ignored) in IDLE, or state in SETUP/ACTIVE/HOLD; low in DONE.
REQ-027 d_out_active = target bc1 & !target bdir for READ, high during ACTIVE and DONE only.
REQ-028 Chip select: ts_en & ADDR request with d=8'hFF sets sel=0, d=8'hFE sets sel=1; IDLE goes directly to DONE, no strobes, cpuwait low.
REQ-029 ts_en=0: sel forced 0 next cycle; FE/FF writes treated as ordinary ADDR to chip 0.
REQ-030 sel changes only in IDLE; in-flight cycle keeps its latched target.
REQ-031 en or ts_en drop mid-cycle: current cycle completes unchanged; only new requests gated.
REQ-032 iorq dropping before DONE: sequence completes fully, then IDLE on DONE (no re-trigger).
REQ-033 ay_clk toggles on every clk28 edge where ck35=1, independent of FSM.

Reset
REQ-034 rst_n low: state IDLE, counter 0, sel 0, ay_clk 0, all bdir/bc1 0; d_out_active and cpuwait 0 while in reset.
REQ-035 Reset mid-ACTIVE: strobes drop asynchronously; after release FSM in IDLE, a still-asserted iorq re-triggers a new cycle.

Verification
REQ-036 Defaults, sel=0, FFFD write d=8'h07 -> ay0_bdir=ay0_bc1=1 for exactly 6 cycles starting 2 cycles after accept; ay1 pins stay 0; cpuwait high 1+1+6+2 cycles total.
REQ-037 ts_en=1, FFFD write d=8'hFE -> sel=1, no strobes, cpuwait never high; following BFFD write -> ay1_bdir=1, ay1_bc1=0 for 6 cycles.
REQ-038 sel=1, FFFD read -> ay1_bc1=1 and d_out_active=1 from ACTIVE until iorq low; cpuwait low once DONE reached.
REQ-039 ts_en=0, FFFD write d=8'hFE -> ay0 address latch cycle, sel stays 0.
REQ-040 rst_n low during ACTIVE of WRITE -> all strobes 0 immediately; after release with iorq high -> new SETUP next edge.
REQ-041 BFFD read or m1=1 request -> no strobes, cpuwait 0; ck35 pulses every 8 cycles -> ay_clk period 16 clk28 cycles.
